mac_stream_ctrl: RTL
====================

# mac_stream_ctrl

Parametrised control unit for the streaming multiply-accumulate datapath. Sequences AXI-Stream handshakes on input (i), kernel (k), bias (b) and output (o) channels, issues accumulator and register strobes, and counts taps per output and outputs per frame. Replaces the fixed single-tap controller with a configurable tap count, a run-time frame length, optional bias, o_TLAST and frame-done signalling.

## Interface
- TAPS, 9: i/k beat pairs accumulated per output, ≥1
- BIAS_EN, 1: 1 = one b beat consumed per output; 0 = b channel unused, accumulator cleared instead
- OUT_W, 16: width of frame-length and output counter
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  start-frame pulse, sampled in IDLE only
- n_outputs  in  OUT_W  outputs in frame, latched on accepted start
- i_TVALID, k_TVALID, b_TVALID  in  1  upstream valids
- o_TREADY  in  1  downstream ready
- i_TREADY, k_TREADY, b_TREADY  out  1  upstream readies
- o_TVALID, o_TLAST  out  1  output valid, last output of frame
- acc_clr  out  1  clear accumulator (BIAS_EN=0)
- bias_ld  out  1  load accumulator with b data (BIAS_EN=1)
- acc_en  out  1  accumulate current i*k
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of frame
- tap_cnt  out  $clog2(TAPS+1)  taps consumed for current output
- out_cnt  out  OUT_W  outputs delivered in current frame

## Operation
- States: IDLE, BIAS, ACC, OUT, DONE.
- IDLE: start=1, n_outputs≠0 → latch n_outputs, out_cnt←0, → BIAS. start=1, n_outputs=0 → DONE (done pulse, no stream traffic). start ignored outside IDLE.
- BIAS, BIAS_EN=1: b_TREADY=1; on b_TVALID: bias_ld=1, tap_cnt←0, → ACC. BIAS_EN=0: acc_clr=1 for exactly one cycle, tap_cnt←0, → ACC; b_TREADY held 0.
- ACC: beat = i_TVALID & k_TVALID; i_TREADY = k_TREADY = beat (joint handshake: never consume i without k). acc_en = beat. On beat tap_cnt++; beat with tap_cnt==TAPS-1 → OUT.
- OUT: o_TVALID=1; o_TLAST = (out_cnt == latched n_outputs-1). On o_TREADY: out_cnt++; if o_TLAST → DONE else → BIAS.
- DONE: done=1, → IDLE. out_cnt holds final value until next accepted start.
- All unlisted strobes/readies are 0 in each state.

## Timing
- Reset (reset_n=0 at a clk edge): state IDLE, tap_cnt=0, out_cnt=0, latched length 0; every output 0. Reset mid-frame aborts immediately; no done pulse.
- Cycles per output with no stalls: 1 (BIAS) + TAPS (ACC) + 1 (OUT); first BIAS cycle follows start edge.
- o_TVALID and o_TLAST stable from assertion until handshake; no combinational path o_TREADY → any ready.
- i/k readies combinational from valids in ACC only; b_TREADY and o_TVALID are pure state decodes.
- TAPS=1: ACC lasts one beat. Back-to-back frames: start accepted in IDLE cycle after DONE.
- out_cnt wraps never: n_outputs ≤ 2^OUT_W-1 by construction.

## Structure
- Package mac_stream_ctrl_pkg: state enum (logic [2:0]), tap counter width function.
- One sub-module: mac_stream_cnt (parametrised up-counter with clear, enable, terminal-count flag), instanced twice (tap, output).

## Test plan
- TAPS=4, BIAS_EN=1, n_outputs=2, all valids/ready high → b accepted cycles 1 and 7, acc_en high 4 cycles each output, o_TVALID cycles 6 and 12, o_TLAST on second, done cycle 13.
- Same config, k_TVALID low every other cycle → i_TREADY never high while k_TVALID low; exactly 4 acc_en pulses per output.
- o_TREADY low 5 cycles in OUT → o_TVALID/o_TLAST held constant, state stays OUT, out_cnt unchanged until handshake.
- BIAS_EN=0, n_outputs=1 → b_TREADY never asserted, acc_clr one cycle, done after single output.
- start with n_outputs=0 → done next cycle, no readies asserted; start during ACC ignored.
- reset_n low during ACC at tap_cnt=2 → next cycle all outputs 0, state IDLE, new frame runs normally.

Source files
------------

// File: rtl/mac_stream_ctrl_pkg.sv
// Shared types and helpers for the streaming MAC controller.
package mac_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BIAS = 3'd1,
    ST_ACC  = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Tap counter must hold TAPS itself once the last beat of an output lands.
  function automatic int tap_cnt_w(input int taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/mac_stream_ctrl_if.sv
// AXI-Stream handshake bundle: input, kernel and bias sinks plus the output source.
interface mac_stream_ctrl_if;
  logic i_TVALID;
  logic i_TREADY;
  logic k_TVALID;
  logic k_TREADY;
  logic b_TVALID;
  logic b_TREADY;
  logic o_TVALID;
  logic o_TREADY;
  logic o_TLAST;

  modport master (
    input  i_TVALID, k_TVALID, b_TVALID, o_TREADY,
    output i_TREADY, k_TREADY, b_TREADY, o_TVALID, o_TLAST
  );

  modport slave (
    output i_TVALID, k_TVALID, b_TVALID, o_TREADY,
    input  i_TREADY, k_TREADY, b_TREADY, o_TVALID, o_TLAST
  );
endinterface

// File: rtl/mac_stream_cnt.sv
// Up-counter with synchronous clear (priority over enable) and a terminal-count flag.
module mac_stream_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/mac_stream_ctrl.sv
// Control FSM for the streaming MAC datapath: sequences bias, tap and output
// handshakes and counts taps per output and outputs per frame.
module mac_stream_ctrl
  import mac_stream_ctrl_pkg::*;
#(
  parameter int TAPS    = 9,
  parameter bit BIAS_EN = 1'b1,
  parameter int OUT_W   = 16,
  localparam int TAP_W  = tap_cnt_w(TAPS)
) (
  input  logic               clk,
  input  logic               reset_n,
  mac_stream_ctrl_if.master  strm,
  input  logic               start,
  input  logic [OUT_W-1:0]   n_outputs,
  output logic               acc_clr,
  output logic               bias_ld,
  output logic               acc_en,
  output logic               busy,
  output logic               done,
  output logic [TAP_W-1:0]   tap_cnt,
  output logic [OUT_W-1:0]   out_cnt
);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] n_len_q, n_len_d;
  logic             in_bias, in_acc, in_out;
  logic             beat;
  logic             tap_clr, tap_en, tap_tc;
  logic             out_clr, out_en, out_tc;

  assign in_bias = (state_q == ST_BIAS);
  assign in_acc  = (state_q == ST_ACC);
  assign in_out  = (state_q == ST_OUT);

  // Joint i/k handshake so an input sample is never consumed without its kernel.
  assign beat          = in_acc & strm.i_TVALID & strm.k_TVALID;
  assign strm.i_TREADY = beat;
  assign strm.k_TREADY = beat;
  assign strm.b_TREADY = in_bias & BIAS_EN;
  assign strm.o_TVALID = in_out;
  assign strm.o_TLAST  = in_out & out_tc;

  assign bias_ld = in_bias & BIAS_EN & strm.b_TVALID;
  assign acc_clr = in_bias & ~BIAS_EN;
  assign acc_en  = beat;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    n_len_d = n_len_q;
    tap_clr = 1'b0;
    tap_en  = 1'b0;
    out_clr = 1'b0;
    out_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (n_outputs != '0) begin
            n_len_d = n_outputs;
            out_clr = 1'b1;
            state_d = ST_BIAS;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_BIAS: begin
        if (!BIAS_EN || strm.b_TVALID) begin
          tap_clr = 1'b1;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (beat) begin
          tap_en = 1'b1;
          if (tap_tc) begin
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (strm.o_TREADY) begin
          out_en  = 1'b1;
          state_d = out_tc ? ST_DONE : ST_BIAS;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      n_len_q <= '0;
    end else begin
      state_q <= state_d;
      n_len_q <= n_len_d;
    end
  end

  mac_stream_cnt #(.W(TAP_W)) u_tap_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (tap_clr),
    .en_i     (tap_en),
    .tc_val_i (TAP_W'(TAPS - 1)),
    .cnt_o    (tap_cnt),
    .tc_o     (tap_tc)
  );

  // Terminal count marks the last output of the frame (drives o_TLAST).
  mac_stream_cnt #(.W(OUT_W)) u_out_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (out_clr),
    .en_i     (out_en),
    .tc_val_i (n_len_q - OUT_W'(1)),
    .cnt_o    (out_cnt),
    .tc_o     (out_tc)
  );

endmodule
